// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path.
// Contents: ALU operation codes, instruction formats, opcode/funct values, FSM states and instruction classes.
package mips_ctrl_pkg;

  localparam logic [3:0] ALU_NOP  = 4'h0;
  localparam logic [3:0] ALU_ADD  = 4'h1;
  localparam logic [3:0] ALU_SUB  = 4'h2;
  localparam logic [3:0] ALU_AND  = 4'h3;
  localparam logic [3:0] ALU_OR   = 4'h4;
  localparam logic [3:0] ALU_XOR  = 4'h5;
  localparam logic [3:0] ALU_NOR  = 4'h6;
  localparam logic [3:0] ALU_SLT  = 4'h7;
  localparam logic [3:0] ALU_SLL  = 4'h8;
  localparam logic [3:0] ALU_SRL  = 4'h9;
  localparam logic [3:0] ALU_BEQ  = 4'hA;
  localparam logic [3:0] ALU_BNE  = 4'hB;
  localparam logic [3:0] ALU_JR   = 4'hC;
  localparam logic [3:0] ALU_JALR = 4'hD;
  localparam logic [3:0] ALU_J    = 4'hE;
  localparam logic [3:0] ALU_JAL  = 4'hF;

  localparam logic [1:0] TYPE_R   = 2'b00;
  localparam logic [1:0] TYPE_I   = 2'b01;
  localparam logic [1:0] TYPE_J   = 2'b10;
  localparam logic [1:0] TYPE_BAD = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {IF, ID, EX, MEM, WB} state_e;

  typedef enum logic [3:0] {RALU, IALU, BR, JMP, JR, JLINK, LOAD, STORE, ILL} class_e;

  typedef struct packed {
    class_e     cls;
    logic [3:0] aluOp;
    logic [1:0] itype;
    logic       aluSrc;
    logic       regDst;
    logic       half;
  } decode_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: maps opcode/funct to class, ALU operation and format fields.
module ctrl_decode
  import mips_ctrl_pkg::*;
#(
  parameter bit HALF_EN = 1'b1
) (
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output decode_t    dec_o
);

  class_e     cls;
  logic [3:0] aluOp;

  always_comb begin
    cls   = ILL;
    aluOp = ALU_NOP;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD:  begin cls = RALU;  aluOp = ALU_ADD;  end
          FN_SUB:  begin cls = RALU;  aluOp = ALU_SUB;  end
          FN_AND:  begin cls = RALU;  aluOp = ALU_AND;  end
          FN_OR:   begin cls = RALU;  aluOp = ALU_OR;   end
          FN_XOR:  begin cls = RALU;  aluOp = ALU_XOR;  end
          FN_NOR:  begin cls = RALU;  aluOp = ALU_NOR;  end
          FN_SLT:  begin cls = RALU;  aluOp = ALU_SLT;  end
          FN_SLL:  begin cls = RALU;  aluOp = ALU_SLL;  end
          FN_SRL:  begin cls = RALU;  aluOp = ALU_SRL;  end
          FN_JR:   begin cls = JR;    aluOp = ALU_JR;   end
          FN_JALR: begin cls = JLINK; aluOp = ALU_JALR; end
          default: ;
        endcase
      end
      OP_ADDI: begin cls = IALU;  aluOp = ALU_ADD; end
      OP_ANDI: begin cls = IALU;  aluOp = ALU_AND; end
      OP_SLTI: begin cls = IALU;  aluOp = ALU_SLT; end
      OP_BEQ:  begin cls = BR;    aluOp = ALU_BEQ; end
      OP_BNE:  begin cls = BR;    aluOp = ALU_BNE; end
      OP_J:    begin cls = JMP;   aluOp = ALU_J;   end
      OP_JAL:  begin cls = JLINK; aluOp = ALU_JAL; end
      OP_LW:   begin cls = LOAD;  aluOp = ALU_ADD; end
      OP_SW:   begin cls = STORE; aluOp = ALU_ADD; end
      OP_LH:   if (HALF_EN) begin cls = LOAD;  aluOp = ALU_ADD; end
      OP_SH:   if (HALF_EN) begin cls = STORE; aluOp = ALU_ADD; end
      default: ;
    endcase
  end

  // Format follows the class, except jalr is R-format while jal is J-format.
  always_comb begin
    dec_o       = '0;
    dec_o.cls   = cls;
    dec_o.aluOp = aluOp;
    case (cls)
      RALU, JR:              dec_o.itype = TYPE_R;
      JLINK:                 dec_o.itype = (opcode_i == OP_RTYPE) ? TYPE_R : TYPE_J;
      JMP:                   dec_o.itype = TYPE_J;
      IALU, BR, LOAD, STORE: dec_o.itype = TYPE_I;
      default:               dec_o.itype = TYPE_BAD;
    endcase
    dec_o.aluSrc = (cls == IALU) || (cls == LOAD) || (cls == STORE);
    dec_o.regDst = (cls == RALU) || ((cls == JLINK) && (opcode_i == OP_RTYPE));
    dec_o.half   = (cls != ILL) && ((opcode_i == OP_LH) || (opcode_i == OP_SH));
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: latches the instruction in IF and sequences ID/EX/MEM/WB,
// with data-memory wait states, stall freezing, illegal-instruction flagging and a retire counter.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter bit          HALF_EN     = 1'b1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             stall,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic [3:0]       ALUOp,
  output logic             ALUSrc,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             Jump,
  output logic             Link,
  output logic             DM_enable,
  output logic             DM_read,
  output logic             Half,
  output logic             MemToReg,
  output logic [1:0]       Type,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_retired
);

  localparam logic [3:0] WAIT_INIT = 4'(MEM_LATENCY);

  state_e           state_q, state_d, seqNext;
  logic [5:0]       opcode_q, opcode_d;
  logic [5:0]       funct_q, funct_d;
  logic [3:0]       waitCnt_q, waitCnt_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  decode_t          dec;
  logic             isJump;

  ctrl_decode #(.HALF_EN(HALF_EN)) u_decode (
    .opcode_i (opcode_q),
    .funct_i  (funct_q),
    .dec_o    (dec)
  );

  assign isJump        = dec.cls inside {BR, JMP, JR, JLINK};
  assign instr_retired = retired_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IF;
      opcode_q  <= '0;
      funct_q   <= '0;
      waitCnt_q <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      funct_q   <= funct_d;
      waitCnt_q <= waitCnt_d;
      retired_q <= retired_d;
    end
  end

  // A stalled cycle leaves every register untouched; the last state before IF retires the instruction.
  always_comb begin
    seqNext = IF;
    case (state_q)
      IF:  seqNext = ID;
      ID:  seqNext = (dec.cls == ILL) ? IF : EX;
      EX: begin
        case (dec.cls)
          RALU, IALU, JLINK: seqNext = WB;
          LOAD, STORE:       seqNext = MEM;
          default:           seqNext = IF;
        endcase
      end
      MEM: begin
        if (waitCnt_q != 4'd0)      seqNext = MEM;
        else if (dec.cls == LOAD)   seqNext = WB;
        else                        seqNext = IF;
      end
      WB:      seqNext = IF;
      default: seqNext = IF;
    endcase

    state_d   = state_q;
    opcode_d  = opcode_q;
    funct_d   = funct_q;
    waitCnt_d = waitCnt_q;
    retired_d = retired_q;
    if (!stall) begin
      state_d = seqNext;
      if (state_q == IF) begin
        opcode_d = opcode;
        funct_d  = funct;
      end
      if ((state_q == EX) && (seqNext == MEM)) begin
        waitCnt_d = WAIT_INIT;
      end else if ((state_q == MEM) && (waitCnt_q != 4'd0)) begin
        waitCnt_d = waitCnt_q - 4'd1;
      end
      if ((state_q inside {EX, MEM, WB}) && (seqNext == IF)) begin
        retired_d = retired_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    ALUOp     = ALU_NOP;
    ALUSrc    = 1'b0;
    RegDst    = 1'b0;
    RegWrite  = 1'b0;
    Jump      = 1'b0;
    Link      = 1'b0;
    DM_enable = 1'b0;
    DM_read   = 1'b0;
    Half      = 1'b0;
    MemToReg  = 1'b0;
    Type      = TYPE_R;
    illegal   = 1'b0;

    if (state_q != IF) begin
      ALUOp    = dec.aluOp;
      ALUSrc   = dec.aluSrc;
      RegDst   = dec.regDst;
      Type     = dec.itype;
      Half     = dec.half;
      Link     = (dec.cls == JLINK);
      MemToReg = (dec.cls == LOAD);
    end

    case (state_q)
      IF: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
      end
      ID:  illegal = (dec.cls == ILL) && !stall;
      EX: begin
        Jump    = isJump;
        PCWrite = isJump;
      end
      MEM: begin
        DM_read   = (dec.cls == LOAD);
        DM_enable = (dec.cls == STORE);
      end
      WB:      RegWrite = 1'b1;
      default: ;
    endcase

    // Reset gating makes the enables drop the instant rst rises, before the state register settles.
    if (stall || rst) begin
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      DM_enable = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: a per-instruction phase-list model predicts every cycle of two controller instances.
module tb_multicycle_controller;

  localparam int K_RW = 0, K_JMP = 1, K_LINK = 2, K_LOAD = 3, K_STORE = 4, K_ILL = 5;

  typedef struct packed {
    logic        pcw;
    logic        irw;
    logic [3:0]  aluop;
    logic        alusrc;
    logic        regdst;
    logic        regwr;
    logic        jump;
    logic        link;
    logic        dmen;
    logic        dmrd;
    logic        half;
    logic        m2r;
    logic [1:0]  typ;
    logic        ill;
    logic [31:0] ret;
  } obsT;

  typedef struct {
    string       name;
    logic [31:0] got;
    logic [31:0] want;
  } litT;

  logic       clk = 1'b0;
  logic       rstS [2];
  logic [5:0] opc  [2];
  logic [5:0] fnc  [2];
  logic       stl  [2];

  logic       pcw [2], irw [2], alusrc [2], regdst [2], regwr [2], jump [2], link [2];
  logic       dmen [2], dmrd [2], half [2], m2r [2], ill [2];
  logic [3:0] aluop [2];
  logic [1:0] typ [2];
  logic [31:0] retA;
  logic [1:0]  retB;
  obsT         obs [2];

  int          mlOf [2]     = '{2, 0};
  bit          halfEnOf [2] = '{1'b1, 1'b0};
  logic [31:0] retMask [2]  = '{32'hFFFF_FFFF, 32'h0000_0003};
  logic [31:0] retModel [2];

  obsT   phases [$];
  obsT   expQ [$];
  int    selQ [$];
  string tagQ [$];
  litT   litQ [$];
  int    lastLen;
  int    dmrdSeen [2] = '{0, 0};
  int    passCnt = 0;
  int    totalCnt = 0;

  obsT   curExp, curAct;
  int    curSel;
  string curTag;
  litT   curLit;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_LATENCY(2), .HALF_EN(1'b1), .CNT_W(32)) dutA (
    .clk(clk), .rst(rstS[0]), .opcode(opc[0]), .funct(fnc[0]), .stall(stl[0]),
    .PCWrite(pcw[0]), .IRWrite(irw[0]), .ALUOp(aluop[0]), .ALUSrc(alusrc[0]), .RegDst(regdst[0]),
    .RegWrite(regwr[0]), .Jump(jump[0]), .Link(link[0]), .DM_enable(dmen[0]), .DM_read(dmrd[0]),
    .Half(half[0]), .MemToReg(m2r[0]), .Type(typ[0]), .illegal(ill[0]), .instr_retired(retA)
  );

  multicycle_controller #(.MEM_LATENCY(0), .HALF_EN(1'b0), .CNT_W(2)) dutB (
    .clk(clk), .rst(rstS[1]), .opcode(opc[1]), .funct(fnc[1]), .stall(stl[1]),
    .PCWrite(pcw[1]), .IRWrite(irw[1]), .ALUOp(aluop[1]), .ALUSrc(alusrc[1]), .RegDst(regdst[1]),
    .RegWrite(regwr[1]), .Jump(jump[1]), .Link(link[1]), .DM_enable(dmen[1]), .DM_read(dmrd[1]),
    .Half(half[1]), .MemToReg(m2r[1]), .Type(typ[1]), .illegal(ill[1]), .instr_retired(retB)
  );

  assign obs[0] = {pcw[0], irw[0], aluop[0], alusrc[0], regdst[0], regwr[0], jump[0], link[0],
                   dmen[0], dmrd[0], half[0], m2r[0], typ[0], ill[0], retA};
  assign obs[1] = {pcw[1], irw[1], aluop[1], alusrc[1], regdst[1], regwr[1], jump[1], link[1],
                   dmen[1], dmrd[1], half[1], m2r[1], typ[1], ill[1], 30'd0, retB};

  // Instruction table: sequence kind plus the decode fields held from ID to the end of the instruction.
  function automatic void specRow(input logic [5:0] op, input logic [5:0] fn, input bit halfEn,
                                  output int kind, output obsT d);
    d    = '0;
    kind = K_ILL;
    case (op)
      6'h00: begin
        case (fn)
          6'h20: begin kind = K_RW;  d.aluop = 4'h1; d.regdst = 1'b1; end
          6'h22: begin kind = K_RW;  d.aluop = 4'h2; d.regdst = 1'b1; end
          6'h00: begin kind = K_RW;  d.aluop = 4'h8; d.regdst = 1'b1; end
          6'h08: begin kind = K_JMP; d.aluop = 4'hC; end
          default: ;
        endcase
        d.typ = 2'b00;
      end
      6'h08: begin kind = K_RW;   d.aluop = 4'h1; d.alusrc = 1'b1; d.typ = 2'b01; end
      6'h0A: begin kind = K_RW;   d.aluop = 4'h7; d.alusrc = 1'b1; d.typ = 2'b01; end
      6'h04: begin kind = K_JMP;  d.aluop = 4'hA; d.typ = 2'b01; end
      6'h05: begin kind = K_JMP;  d.aluop = 4'hB; d.typ = 2'b01; end
      6'h02: begin kind = K_JMP;  d.aluop = 4'hE; d.typ = 2'b10; end
      6'h03: begin kind = K_LINK; d.aluop = 4'hF; d.typ = 2'b10; d.link = 1'b1; end
      6'h23: begin kind = K_LOAD; d.aluop = 4'h1; d.typ = 2'b01; d.alusrc = 1'b1; d.m2r = 1'b1; end
      6'h2B: begin kind = K_STORE; d.aluop = 4'h1; d.typ = 2'b01; d.alusrc = 1'b1; end
      6'h21: if (halfEn) begin
        kind = K_LOAD; d.aluop = 4'h1; d.typ = 2'b01; d.alusrc = 1'b1; d.m2r = 1'b1; d.half = 1'b1;
      end
      6'h29: if (halfEn) begin
        kind = K_STORE; d.aluop = 4'h1; d.typ = 2'b01; d.alusrc = 1'b1; d.half = 1'b1;
      end
      default: ;
    endcase
    if (kind == K_ILL) d = '0;
  endfunction

  task automatic buildPhases(input logic [5:0] op, input logic [5:0] fn, input int ml,
                             input bit halfEn, output bit legal);
    obsT d, e;
    int  kind;
    specRow(op, fn, halfEn, kind, d);
    phases.delete();
    e = '0; e.pcw = 1'b1; e.irw = 1'b1;
    phases.push_back(e);
    legal = (kind != K_ILL);
    if (!legal) begin
      e = '0; e.typ = 2'b11; e.ill = 1'b1;
      phases.push_back(e);
      return;
    end
    phases.push_back(d);
    case (kind)
      K_RW: begin
        phases.push_back(d);
        e = d; e.regwr = 1'b1; phases.push_back(e);
      end
      K_JMP: begin
        e = d; e.jump = 1'b1; e.pcw = 1'b1; phases.push_back(e);
      end
      K_LINK: begin
        e = d; e.jump = 1'b1; e.pcw = 1'b1; phases.push_back(e);
        e = d; e.regwr = 1'b1; phases.push_back(e);
      end
      K_LOAD: begin
        phases.push_back(d);
        e = d; e.dmrd = 1'b1;
        for (int i = 0; i <= ml; i++) phases.push_back(e);
        e = d; e.regwr = 1'b1; phases.push_back(e);
      end
      default: begin
        phases.push_back(d);
        e = d; e.dmen = 1'b1;
        for (int i = 0; i <= ml; i++) phases.push_back(e);
      end
    endcase
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    litT l;
    l.name = name;
    l.got  = got;
    l.want = want;
    litQ.push_back(l);
  endtask

  // Entered and left at posedge+1; each loop pass describes one DUT cycle.
  task automatic applyStimulus(input int sel, input string name, input logic [5:0] op,
                               input logic [5:0] fn, input int stallAt, input int stallLen,
                               input int abortAt);
    bit  legal;
    int  p, c, stalled;
    bit  stallNow;
    obsT e;
    buildPhases(op, fn, mlOf[sel], halfEnOf[sel], legal);
    lastLen = phases.size();
    p = 0; c = 0; stalled = 0;
    while (p < phases.size()) begin
      if (c == abortAt) begin
        rstS[sel] = 1'b1;
        #1;
        checkOutput({name, "_abort_enables"},
                    32'({obs[sel].pcw, obs[sel].irw, obs[sel].regwr, obs[sel].dmen, obs[sel].dmrd, obs[sel].ill}), 32'd0);
        checkOutput({name, "_abort_retired"}, obs[sel].ret, 32'd0);
        @(posedge clk); #1;
        rstS[sel] = 1'b0;
        retModel[sel] = 32'd0;
        stl[sel] = 1'b0;
        return;
      end
      stallNow = (p == stallAt) && (stalled < stallLen);
      opc[sel] = (p == 0) ? op : 6'h3F;
      fnc[sel] = (p == 0) ? fn : 6'h3F;
      stl[sel] = stallNow;
      e = phases[p];
      e.ret = retModel[sel];
      if (stallNow) begin
        e.pcw = 1'b0; e.irw = 1'b0; e.regwr = 1'b0; e.dmen = 1'b0; e.ill = 1'b0;
        stalled++;
      end else begin
        if (legal && (p == phases.size() - 1)) retModel[sel] = (retModel[sel] + 32'd1) & retMask[sel];
        p++;
      end
      expQ.push_back(e);
      selQ.push_back(sel);
      tagQ.push_back($sformatf("%s_c%0d", name, c));
      @(posedge clk); #1;
      c++;
    end
    stl[sel] = 1'b0;
  endtask

  // Single compare process: drains literal checks, then the model's expectation for this cycle.
  always @(negedge clk) begin
    while (litQ.size() > 0) begin
      curLit = litQ.pop_front();
      totalCnt++;
      if (curLit.got === curLit.want) passCnt++;
      else $display("[TB] FAIL %s: got %0d expected %0d", curLit.name, curLit.got, curLit.want);
    end
    if (expQ.size() > 0) begin
      curExp = expQ.pop_front();
      curSel = selQ.pop_front();
      curTag = tagQ.pop_front();
      curAct = obs[curSel];
      totalCnt++;
      if (curAct === curExp) passCnt++;
      else $display("[TB] FAIL %s: got %p expected %p", curTag, curAct, curExp);
      if (curAct.dmrd === 1'b1) dmrdSeen[curSel]++;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int dmBefore;
    for (int i = 0; i < 2; i++) begin
      rstS[i] = 1'b1; opc[i] = 6'h00; fnc[i] = 6'h00; stl[i] = 1'b0; retModel[i] = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_enables", 32'({pcw[0], irw[0], regwr[0], dmen[0], ill[0]}), 32'd0);
    checkOutput("reset_retired", retA, 32'd0);
    checkOutput("reset_aluop", 32'(aluop[0]), 32'd0);
    rstS[0] = 1'b0;

    $display("[TB] instance A: MEM_LATENCY=2 HALF_EN=1");
    applyStimulus(0, "add", 6'h00, 6'h20, -1, 0, -1);
    checkOutput("add_len", lastLen, 32'd4);
    checkOutput("add_retired", retA, 32'd1);
    applyStimulus(0, "sub",  6'h00, 6'h22, -1, 0, -1);
    applyStimulus(0, "sll",  6'h00, 6'h00, -1, 0, -1);
    applyStimulus(0, "addi", 6'h08, 6'h15, -1, 0, -1);
    applyStimulus(0, "slti", 6'h0A, 6'h00, -1, 0, -1);
    applyStimulus(0, "beq",  6'h04, 6'h00, -1, 0, -1);
    checkOutput("beq_len", lastLen, 32'd3);
    applyStimulus(0, "bne",  6'h05, 6'h00, -1, 0, -1);
    applyStimulus(0, "j",    6'h02, 6'h00, -1, 0, -1);
    applyStimulus(0, "jal",  6'h03, 6'h00, -1, 0, -1);
    checkOutput("jal_len", lastLen, 32'd4);
    applyStimulus(0, "jr",   6'h00, 6'h08, -1, 0, -1);
    checkOutput("jr_len", lastLen, 32'd3);
    dmBefore = dmrdSeen[0];
    applyStimulus(0, "lw",   6'h23, 6'h00, -1, 0, -1);
    checkOutput("lw_len", lastLen, 32'd7);
    checkOutput("lw_dmread_cycles", 32'(dmrdSeen[0] - dmBefore), 32'd3);
    applyStimulus(0, "sw_stall", 6'h2B, 6'h00, 4, 3, -1);
    checkOutput("sw_len", lastLen, 32'd6);
    applyStimulus(0, "sh",   6'h29, 6'h00, -1, 0, -1);
    applyStimulus(0, "lh",   6'h21, 6'h00, -1, 0, -1);
    applyStimulus(0, "badop_stall", 6'h3F, 6'h00, 1, 2, -1);
    applyStimulus(0, "badfn", 6'h00, 6'h3F, -1, 0, -1);
    checkOutput("badfn_len", lastLen, 32'd2);
    checkOutput("retired_14", retA, 32'd14);
    applyStimulus(0, "lw_abort", 6'h23, 6'h00, -1, 0, 4);
    applyStimulus(0, "add_after_rst", 6'h00, 6'h20, -1, 0, -1);
    checkOutput("final_retired", retA, 32'd1);
    rstS[0] = 1'b1;

    $display("[TB] instance B: MEM_LATENCY=0 HALF_EN=0 CNT_W=2");
    rstS[1] = 1'b0;
    applyStimulus(1, "sh_nohalf", 6'h29, 6'h00, -1, 0, -1);
    checkOutput("sh_nohalf_len", lastLen, 32'd2);
    checkOutput("sh_nohalf_retired", 32'(retB), 32'd0);
    applyStimulus(1, "lh_nohalf", 6'h21, 6'h00, -1, 0, -1);
    for (int i = 0; i < 4; i++) applyStimulus(1, $sformatf("swB%0d", i), 6'h2B, 6'h00, -1, 0, -1);
    checkOutput("swB_len", lastLen, 32'd4);
    checkOutput("retired_wrap", 32'(retB), 32'd0);
    applyStimulus(1, "lwB", 6'h23, 6'h00, -1, 0, -1);
    checkOutput("lwB_len", lastLen, 32'd5);
    checkOutput("lwB_retired", 32'(retB), 32'd1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multi-cycle successor to the single-cycle MIPS control decoder. Latches opcode/funct at fetch and sequences each instruction through IF/ID/EX/MEM/WB states. Adds configurable data-memory latency, a stall input, illegal-instruction detection and a retired-instruction counter. Sits between the instruction register and the shared multi-cycle datapath (PC, RF, ALU, DM).

Parameters:
MEM_LATENCY, 1, extra DM wait cycles per load/store (0..15).
HALF_EN, 1, 1 = lh/sh supported; 0 = opcodes 6'h21/6'h29 treated as illegal.
CNT_W, 32, width of instr_retired counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
opcode  in  6  instruction[31:26]; sampled only when IRWrite=1
funct  in  6  instruction[5:0]; sampled only when IRWrite=1
stall  in  1  freeze FSM and counters; all write enables forced 0
PCWrite  out  1  PC <= PC+4 (in IF) or jump/branch target (in EX)
IRWrite  out  1  latch instruction
ALUOp  out  4  NOP0 ADD1 SUB2 AND3 OR4 XOR5 NOR6 SLT7 SLL8 SRL9 BEQ A BNE B JR C JALR D J E JAL F
ALUSrc, RegDst, RegWrite, Jump, Link, DM_enable, DM_read, Half, MemToReg  out  1 each
Type  out  2  TR=00 TI=01 TJ=10 invalid=11
illegal  out  1  one-cycle pulse on unknown opcode/funct
instr_retired  out  CNT_W  count of completed instructions

Behaviour:
- Async reset: state=IF, latched opcode/funct=0, wait counter=0, instr_retired=0, illegal=0. All write enables (PCWrite, IRWrite, RegWrite, DM_enable) are 0 while rst=1.
- Outputs are combinational from state and the latched fields. Decode fields (ALUOp, ALUSrc, RegDst, Type, Half, Link, MemToReg) are held constant from ID until return to IF. All other outputs are 0 outside the states listed below.
- IF: IRWrite=1, PCWrite=1 (PC+4), ALUOp=NOP. Next state is ID.
- ID: classify the latched instruction.
  - Unknown opcode, unknown R-funct, or lh/sh with HALF_EN=0: illegal=1 for this cycle, Type=11, go to IF. No RF/DM write; not counted as retired.
- Sequences (states after ID), with cycles per instruction:
  - R ALU (add sub and or xor nor slt sll srl): EX, then WB (RegWrite=1, RegDst=1). 4 cycles.
  - I ALU (addi andi slti): EX (ALUSrc=1), then WB (RegWrite=1, RegDst=0). 4 cycles.
  - beq/bne: EX (Jump=1; PCWrite=1 qualified by the datapath zero flag). 3 cycles.
  - j: EX (Jump=1, PCWrite=1). 3 cycles.
  - jr: EX (Jump=1, PCWrite=1). 3 cycles.
  - jal/jalr: EX (Jump=1, PCWrite=1), then WB (Link=1, RegWrite=1). 4 cycles.
  - lw/lh: EX (ADD, ALUSrc=1), then MEM (DM_read=1 for MEM_LATENCY+1 cycles), then WB (MemToReg=1, RegWrite=1). 5+MEM_LATENCY cycles.
  - sw/sh: EX, then MEM (DM_enable=1 for MEM_LATENCY+1 cycles). 4+MEM_LATENCY cycles.
  - Half=1 for lh/sh across EX/MEM/WB.
- MEM wait counter: loaded with MEM_LATENCY on EX->MEM; decrements each unstalled MEM cycle; leave MEM when it reads 0. With MEM_LATENCY=0, MEM lasts exactly one cycle.
- instr_retired increments by 1 on the final cycle of each legal instruction (the last state before IF). It wraps modulo 2^CNT_W.
- stall=1: state, counter, latched fields and instr_retired hold. PCWrite, IRWrite, RegWrite and DM_enable are 0. Decode outputs stay valid. illegal is not re-pulsed. The sequence resumes on the first cycle with stall=0.
- Reset asserted mid-instruction: outputs drop to reset values immediately (async); the in-flight instruction is abandoned.
- Opcode/funct changes outside IF have no effect.

Decomposition:
- Package mips_ctrl_pkg holds:
  - ALUOp codes, Type codes, opcode and funct constants;
  - the state enum (IF, ID, EX, MEM, WB);
  - the instruction-class enum (RALU, IALU, BR, JMP, JR, JLINK, LOAD, STORE, ILL).
- One sub-module, ctrl_decode: purely combinational. Maps opcode/funct/HALF_EN to class, ALUOp, Type, ALUSrc, RegDst and Half. The FSM instantiates it on the latched fields.

Test Plan:
- add (op 0, funct 0x20) after reset: IF/ID/EX/WB over 4 cycles; WB has RegWrite=1, RegDst=1, ALUOp=1; instr_retired goes 0->1.
- lw (op 0x23) with MEM_LATENCY=2: DM_read=1 for exactly 3 cycles, then WB with MemToReg=1, RegWrite=1; total 7 cycles.
- sh (op 0x29): with HALF_EN=1, DM_enable=1 and Half=1 for MEM_LATENCY+1 cycles, RegWrite never 1. With HALF_EN=0: illegal pulses in ID, back to IF, instr_retired unchanged.
- jal (op 0x03): EX has Jump=1, PCWrite=1, ALUOp=F; WB has Link=1, RegWrite=1. Then jr (funct 0x08): 3 cycles, RegWrite stays 0.
- Stall for 3 cycles during MEM of sw: DM_enable=0 and state/counter frozen while stalled; DM_enable then completes its remaining cycles after release.
- rst pulsed during MEM of lw: all write enables 0 at once; after release, IF with IRWrite=1 and instr_retired=0.
